// File: rtl/psg_mix_pkg.sv
// Shared types and weight rules for the PSG stereo mixer.
// Pure definitions; no clocked logic, so no latency.
// No flow control lives here; the mixer handles overrun itself.
package psg_mix_pkg;

    typedef enum logic [1:0] {
        MIX_MONO   = 2'd0,
        MIX_ABC    = 2'd1,
        MIX_ACB    = 2'd2,
        MIX_CUSTOM = 2'd3
    } mix_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } mix_state_e;

    localparam logic [1:0] W_OFF  = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_FULL = 2'd2;

    localparam logic SIDE_L = 1'b0;
    localparam logic SIDE_R = 1'b1;

    // Weight of one channel on one side. Channels 3 and up are extra tone
    // channels with no fixed stereo position, so the preset layouts put
    // them at half level in the centre. A custom weight of 3 saturates
    // to full so the sum bound on the accumulator still holds.
    function automatic logic [1:0] mix_weight(mix_mode_e mode, logic [3:0] chan,
                                              logic side, logic [1:0] custom_wt);
        logic [1:0] w;
        w = W_FULL;
        case (mode)
            MIX_MONO: w = W_FULL;
            MIX_ABC: begin
                if (chan >= 4'd3)        w = W_HALF;
                else if (side == SIDE_L) w = (chan == 4'd2) ? W_OFF : W_FULL;
                else                     w = (chan == 4'd0) ? W_OFF : W_FULL;
            end
            MIX_ACB: begin
                if (chan >= 4'd3)        w = W_HALF;
                else if (side == SIDE_L) w = (chan == 4'd1) ? W_OFF : W_FULL;
                else                     w = (chan == 4'd0) ? W_OFF : W_FULL;
            end
            MIX_CUSTOM: w = (custom_wt == 2'd3) ? W_FULL : custom_wt;
            default: w = W_FULL;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/psg_stereo_mixer.sv
// Time-multiplexed stereo mixer: snapshot N channel levels, accumulate one per clock.
// Latency: ce_sample at cycle t -> sample_valid/audio at t+NCH+1; one mix per NCH+2 cycles.
// No backpressure: ce_sample while busy (incl. DONE) is dropped and flagged on overrun.
module psg_stereo_mixer
    import psg_mix_pkg::*;
#(
    parameter int NCH   = 3,
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                ce_sample,
    input  logic [NCH*IN_W-1:0] ch_in,
    input  logic [1:0]          mode,
    input  logic [2*NCH-1:0]    wt_l,
    input  logic [2*NCH-1:0]    wt_r,
    output logic [OUT_W-1:0]    audio_l,
    output logic [OUT_W-1:0]    audio_r,
    output logic                sample_valid,
    output logic                busy,
    output logic                overrun
);

    // Each channel contributes at most 2*max level, so NCH channels fit here.
    localparam int ACC_W = IN_W + $clog2(2 * NCH);
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    mix_state_e          state_q;
    logic [NCH*IN_W-1:0] ch_q;
    mix_mode_e           mode_q;
    logic [2*NCH-1:0]    wl_q;
    logic [2*NCH-1:0]    wr_q;
    logic [IDX_W-1:0]    idx_q;
    logic [ACC_W-1:0]    acc_l_q;
    logic [ACC_W-1:0]    acc_r_q;
    logic [OUT_W-1:0]    audio_l_q;
    logic [OUT_W-1:0]    audio_r_q;
    logic                valid_q;
    logic                busy_q;
    logic                overrun_q;

    logic [IN_W-1:0]     cur_ch;
    logic [1:0]          cur_wl;
    logic [1:0]          cur_wr;
    logic [1:0]          eff_wl;
    logic [1:0]          eff_wr;
    logic [ACC_W-1:0]    acc_l_d;
    logic [ACC_W-1:0]    acc_r_d;
    logic [OUT_W-1:0]    just_l;
    logic [OUT_W-1:0]    just_r;
    logic                last_ch;

    // Weight <= 2, so the product is a pass-through or a single left shift.
    function automatic logic [ACC_W-1:0] scale(logic [IN_W-1:0] v, logic [1:0] w);
        logic [ACC_W-1:0] t;
        case (w)
            W_OFF:   t = '0;
            W_HALF:  t = ACC_W'(v);
            default: t = ACC_W'(v) << 1;
        endcase
        return t;
    endfunction

    // Select the snapshot level and raw custom weights of the channel being summed.
    always_comb begin
        cur_ch = '0;
        cur_wl = '0;
        cur_wr = '0;
        for (int k = 0; k < NCH; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_ch = ch_q[k*IN_W +: IN_W];
                cur_wl = wl_q[2*k +: 2];
                cur_wr = wr_q[2*k +: 2];
            end
        end
    end

    assign eff_wl  = mix_weight(mode_q, 4'(idx_q), SIDE_L, cur_wl);
    assign eff_wr  = mix_weight(mode_q, 4'(idx_q), SIDE_R, cur_wr);
    assign acc_l_d = acc_l_q + scale(cur_ch, eff_wl);
    assign acc_r_d = acc_r_q + scale(cur_ch, eff_wr);
    assign last_ch = (idx_q == IDX_W'(NCH - 1));

    // Left-justify the finished sum into the output width, zero-filling low bits.
    generate
        if (OUT_W >= ACC_W) begin : g_widen
            assign just_l = OUT_W'(acc_l_d) << (OUT_W - ACC_W);
            assign just_r = OUT_W'(acc_r_d) << (OUT_W - ACC_W);
        end else begin : g_trunc
            assign just_l = acc_l_d[ACC_W-1 -: OUT_W];
            assign just_r = acc_r_d[ACC_W-1 -: OUT_W];
        end
    endgenerate

    // Mix sequencer: snapshot on strobe, one channel per clock, publish on the last add.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            mode_q    <= MIX_MONO;
            wl_q      <= '0;
            wr_q      <= '0;
            idx_q     <= '0;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            audio_l_q <= '0;
            audio_r_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ce_sample) begin
                        ch_q    <= ch_in;
                        mode_q  <= mix_mode_e'(mode);
                        wl_q    <= wt_l;
                        wr_q    <= wt_r;
                        acc_l_q <= '0;
                        acc_r_q <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    overrun_q <= ce_sample;
                    acc_l_q   <= acc_l_d;
                    acc_r_q   <= acc_r_d;
                    idx_q     <= idx_q + IDX_W'(1);
                    // Outputs land with the final add so they are visible in DONE.
                    if (last_ch) begin
                        audio_l_q <= just_l;
                        audio_r_q <= just_r;
                        valid_q   <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    overrun_q <= ce_sample;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign audio_l      = audio_l_q;
    assign audio_r      = audio_r_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_psg_stereo_mixer.sv
// Scoreboard bench for psg_stereo_mixer: two configurations (3x8 bit, 5x4 bit).
// Driver pushes expected mixes/overruns into queues; a negedge monitor pops and compares.
// Reference model works from the weight table and plain sums, not from the RTL state machine.
module tb_psg_stereo_mixer;

    localparam int NA = 3, IA = 8, NB = 5, IB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               ce_a, ce_b;
    logic [NA*IA-1:0]   ch_a;
    logic [NB*IB-1:0]   ch_b;
    logic [1:0]         mode_a, mode_b;
    logic [2*NA-1:0]    wl_a, wr_a;
    logic [2*NB-1:0]    wl_b, wr_b;
    logic [15:0]        l_a, r_a, l_b, r_b;
    logic               v_a, v_b, busy_a, busy_b, ovr_a, ovr_b;

    psg_stereo_mixer #(.NCH(NA), .IN_W(IA), .OUT_W(16)) dut_a (
        .clk_sys(clk), .reset_n(rst_n), .ce_sample(ce_a), .ch_in(ch_a), .mode(mode_a),
        .wt_l(wl_a), .wt_r(wr_a), .audio_l(l_a), .audio_r(r_a),
        .sample_valid(v_a), .busy(busy_a), .overrun(ovr_a));

    psg_stereo_mixer #(.NCH(NB), .IN_W(IB), .OUT_W(16)) dut_b (
        .clk_sys(clk), .reset_n(rst_n), .ce_sample(ce_b), .ch_in(ch_b), .mode(mode_b),
        .wt_l(wl_b), .wt_r(wr_b), .audio_l(l_b), .audio_r(r_b),
        .sample_valid(v_b), .busy(busy_b), .overrun(ovr_b));

    typedef struct packed {int l; int r; int cyc;} exp_t;

    exp_t sb_a[$], sb_b[$];
    int   ov_a[$], ov_b[$];

    int vec = 0;
    int err = 0;
    int cyc = 0;

    int nch[2] = '{NA, NB};
    int inw[2] = '{IA, IB};
    int free_at[2], acc_t[2], last_l[2], last_r[2];

    int ch_s[2][8], wl_s[2][8], wr_s[2][8], mode_s[2];
    bit ce_s[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input int id, input int act, input int req);
        vec++;
        if (act != req) begin
            err++;
            $display("FAIL %s dut%0d cyc=%0d: got %0d, expected %0d", name, id, cyc, act, req);
        end
    endtask

    function automatic int ref_wt(int mode, int k, bit right, int cw);
        case (mode)
            0: return 2;
            1: begin
                if (k >= 3) return 1;
                if (!right) return (k == 2) ? 0 : 2;
                return (k == 0) ? 0 : 2;
            end
            2: begin
                if (k >= 3) return 1;
                if (!right) return (k == 1) ? 0 : 2;
                return (k == 0) ? 0 : 2;
            end
            default: return (cw == 3) ? 2 : cw;
        endcase
    endfunction

    task automatic ref_mix(input int id, output int l, output int r);
        int sl, sr, accw;
        sl = 0; sr = 0; accw = 0;
        for (int k = 0; k < nch[id]; k++) begin
            sl += ch_s[id][k] * ref_wt(mode_s[id], k, 1'b0, wl_s[id][k]);
            sr += ch_s[id][k] * ref_wt(mode_s[id], k, 1'b1, wr_s[id][k]);
        end
        while ((1 << accw) < 2 * nch[id]) accw++;
        accw += inw[id];
        if (accw <= 16) begin
            l = sl << (16 - accw);
            r = sr << (16 - accw);
        end else begin
            l = sl >> (accw - 16);
            r = sr >> (accw - 16);
        end
    endtask

    task automatic rand_stim(input int id);
        ce_s[id]   = 1'b0;
        mode_s[id] = $urandom_range(3, 0);
        for (int k = 0; k < 8; k++) begin
            ch_s[id][k] = $urandom_range((1 << inw[id]) - 1, 0);
            wl_s[id][k] = $urandom_range(3, 0);
            wr_s[id][k] = $urandom_range(3, 0);
        end
    endtask

    task automatic model_clear();
        sb_a.delete(); sb_b.delete(); ov_a.delete(); ov_b.delete();
        for (int id = 0; id < 2; id++) begin
            free_at[id] = 0; acc_t[id] = -100; last_l[id] = 0; last_r[id] = 0;
        end
    endtask

    // Apply this cycle's stimulus to one DUT and record what it must produce.
    task automatic drive(input int id);
        int l, r;
        exp_t e;
        if (id == 0) begin
            ce_a = ce_s[0]; mode_a = 2'(mode_s[0]);
            for (int k = 0; k < NA; k++) begin
                ch_a[k*IA +: IA] = IA'(ch_s[0][k]);
                wl_a[2*k +: 2] = 2'(wl_s[0][k]);
                wr_a[2*k +: 2] = 2'(wr_s[0][k]);
            end
        end else begin
            ce_b = ce_s[1]; mode_b = 2'(mode_s[1]);
            for (int k = 0; k < NB; k++) begin
                ch_b[k*IB +: IB] = IB'(ch_s[1][k]);
                wl_b[2*k +: 2] = 2'(wl_s[1][k]);
                wr_b[2*k +: 2] = 2'(wr_s[1][k]);
            end
        end
        if (ce_s[id] && rst_n) begin
            if (cyc >= free_at[id]) begin
                ref_mix(id, l, r);
                e.l = l; e.r = r; e.cyc = cyc + nch[id] + 1;
                if (id == 0) sb_a.push_back(e); else sb_b.push_back(e);
                acc_t[id]   = cyc;
                free_at[id] = cyc + nch[id] + 2;
            end else begin
                if (id == 0) ov_a.push_back(cyc + 1); else ov_b.push_back(cyc + 1);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive(0);
        drive(1);
        rand_stim(0);
        rand_stim(1);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        ce_a = 1'b0; ce_b = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Wait a bounded time for the next sample and compare against literal values.
    task automatic expect_out(input int id, input string name, input int el, input int er);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            @(negedge clk);
            if ((id == 0) ? v_a : v_b) begin
                found = 1'b1;
                cmp({name, "_l"}, id, (id == 0) ? l_a : l_b, el);
                cmp({name, "_r"}, id, (id == 0) ? r_a : r_b, er);
            end
        end
        if (!found) cmp({name, "_timeout"}, id, 0, 1);
    endtask

    task automatic check(input int id, input logic v, input logic [15:0] l,
                         input logic [15:0] r, input logic b, input logic o);
        exp_t e;
        int   n;
        bit   eb, eo;
        n = (id == 0) ? sb_a.size() : sb_b.size();
        if (v) begin
            if (n == 0) begin
                cmp("valid_unexpected", id, 1, 0);
            end else begin
                if (id == 0) e = sb_a.pop_front(); else e = sb_b.pop_front();
                cmp("audio_l", id, l, e.l);
                cmp("audio_r", id, r, e.r);
                cmp("latency", id, cyc, e.cyc);
                last_l[id] = e.l;
                last_r[id] = e.r;
            end
        end else begin
            cmp("hold_l", id, l, last_l[id]);
            cmp("hold_r", id, r, last_r[id]);
        end
        eb = (cyc > acc_t[id]) && (cyc < free_at[id]);
        cmp("busy", id, b, eb);
        eo = 1'b0;
        if (id == 0) begin
            if (ov_a.size() > 0 && ov_a[0] == cyc) begin eo = 1'b1; void'(ov_a.pop_front()); end
        end else begin
            if (ov_b.size() > 0 && ov_b[0] == cyc) begin eo = 1'b1; void'(ov_b.pop_front()); end
        end
        cmp("overrun", id, o, eo);
    endtask

    // Monitor: every cycle, away from the active edge.
    always @(negedge clk) begin
        check(0, v_a, l_a, r_a, busy_a, ovr_a);
        check(1, v_b, l_b, r_b, busy_b, ovr_b);
    end

    task automatic set_dir(input int id, input int m, input int c0, input int c1, input int c2);
        mode_s[id] = m;
        ce_s[id]   = 1'b1;
        ch_s[id][0] = c0; ch_s[id][1] = c1; ch_s[id][2] = c2;
    endtask

    initial begin
        rst_n = 1'b0;
        model_clear();
        rand_stim(0);
        rand_stim(1);
        drive(0);
        drive(1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Mono, full scale
        set_dir(0, 0, 255, 255, 255);
        tick();
        expect_out(0, "mono", 48960, 48960);

        // ABC layout
        set_dir(0, 1, 100, 50, 10);
        tick();
        expect_out(0, "abc", 9600, 3840);

        // ACB layout
        set_dir(0, 2, 100, 50, 10);
        tick();
        expect_out(0, "acb", 7040, 3840);

        // Custom pan
        set_dir(0, 3, 64, 64, 64);
        wl_s[0][0] = 1; wl_s[0][1] = 0; wl_s[0][2] = 2;
        wr_s[0][0] = 0; wr_s[0][1] = 1; wr_s[0][2] = 0;
        tick();
        expect_out(0, "custom", 6144, 2048);

        // Dropped strobe at t+2, inputs changing at t+1
        set_dir(0, 0, 10, 20, 30);
        tick();
        tick();
        ce_s[0] = 1'b1;
        tick();
        expect_out(0, "overrun_mix", 3840, 3840);

        // Reset two cycles into a mix on both instances
        set_dir(0, 0, 255, 255, 255);
        set_dir(1, 0, 15, 15, 15);
        tick();
        tick();
        reset_pulse();
        @(negedge clk);
        cmp("rst_audio_l", 0, l_a, 0);
        cmp("rst_busy", 1, busy_b, 0);

        // Recovery on the 5-channel, 4-bit instance
        set_dir(1, 0, 15, 15, 15);
        ch_s[1][3] = 15; ch_s[1][4] = 15;
        tick();
        expect_out(1, "mono5", 38400, 38400);
        set_dir(0, 1, 100, 50, 10);
        tick();
        expect_out(0, "abc_post_rst", 9600, 3840);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            ce_s[0] = ($urandom_range(3, 0) == 0);
            ce_s[1] = ($urandom_range(3, 0) == 0);
            if ($urandom_range(599, 0) == 0) reset_pulse();
            tick();
        end
        repeat (20) tick();
        @(negedge clk);
        cmp("drain_sb", 0, sb_a.size(), 0);
        cmp("drain_sb", 1, sb_b.size(), 0);
        cmp("drain_ov", 0, ov_a.size(), 0);
        cmp("drain_ov", 1, ov_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
